stream_mux_rr: RTL

Parametrised N-channel streaming multiplexer: the registered, handshaked successor to the team's fixed 4:1 select mux. It merges `N_CH` valid/ready input streams onto one output stream through a single output register. Arbitration is round-robin, with optional packet locking and a forced-select mode that reproduces the old fixed-select behaviour. It sits between per-channel producers and a single shared consumer.

---
 rtl/stream_mux_pkg.sv | 29 ++
 rtl/stream_mux_rr_arbiter.sv | 26 ++
 rtl/stream_mux_rr.sv | 129 ++++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: channel-index
// width helper and the round-robin pick function used by the arbiter.
package stream_mux_pkg;

  // Widest channel count the pick function handles.
  localparam int MAX_CH = 64;

  // Width of a channel index; never less than one bit.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One-hot grant of the first requester after ptr, wrapping at n.
  function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                                input int               ptr,
                                                input int               n);
    logic [MAX_CH-1:0] g;
    int                c;
    g = '0;
    for (int k = 1; k <= MAX_CH; k++) begin
      if (k <= n) begin
        c = (ptr + k) % n;
        if (g == '0 && req[c]) g[c] = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus its binary index.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = ch_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [CW-1:0] grant_idx
);

  logic [MAX_CH-1:0] w_req_ext;

  // Search starts just after ptr; index is zero when nothing is granted.
  always_comb begin
    w_req_ext = MAX_CH'(req);
    grant     = N'(rr_pick(w_req_ext, int'(ptr), N));
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = CW'(i);
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a single output register,
// round-robin arbitration, optional packet locking and a fixed-select mode.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int DATA_W   = 8,
  parameter int LOCK_PKT = 1,
  localparam int CH_W    = ch_w(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_last,
  output logic [N_CH-1:0]          in_ready,
  input  logic                     force_en,
  input  logic [CH_W-1:0]          force_sel,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic [CH_W-1:0]   r_out_ch;
  logic [CH_W-1:0]   r_ptr;
  logic              r_locked;
  logic [CH_W-1:0]   r_lock_ch;

  logic              w_ld;
  logic              w_force_act;
  logic [N_CH-1:0]   w_req;
  logic [N_CH-1:0]   w_grant;
  logic [CH_W-1:0]   w_gidx;
  logic [N_CH-1:0]   w_ready;
  logic              w_acc;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_last;

  // Forced mode is only honoured between packets; a held lock overrides it.
  assign w_force_act = force_en & ~r_locked;

  // Eligible requests: locked channel, forced channel, or everyone.
  always_comb begin
    w_req = '0;
    if (r_locked) begin
      w_req = in_valid & (N_CH'(1) << r_lock_ch);
    end else if (w_force_act) begin
      if (int'(force_sel) < N_CH) w_req = in_valid & (N_CH'(1) << force_sel);
    end else begin
      w_req = in_valid;
    end
  end

  rr_arbiter #(
    .N  (N_CH),
    .CW (CH_W)
  ) u_arb (
    .req       (w_req),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_gidx)
  );

  // Output register can take a beat when empty or draining this cycle;
  // rst_n gating keeps in_ready low for the whole reset window.
  assign w_ld     = ~r_out_valid | out_ready;
  assign w_ready  = w_grant & {N_CH{w_ld & rst_n}};
  assign w_acc    = |w_ready;
  assign in_ready = w_ready;

  // Route the granted channel's payload toward the output register.
  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (w_grant[c]) begin
        w_sel_data = in_data[c*DATA_W +: DATA_W];
        w_sel_last = in_last[c];
      end
    end
  end

  // Round-robin pointer and packet lock tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= CH_W'(N_CH - 1);
      r_locked  <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_acc) begin
      if (!w_force_act) r_ptr <= w_gidx;
      if (LOCK_PKT != 0) begin
        if (!w_sel_last) begin
          r_locked  <= 1'b1;
          r_lock_ch <= w_gidx;
        end else begin
          r_locked  <= 1'b0;
        end
      end
    end
  end

  // Output register: load on accept, empty on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_ch    <= '0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_last  <= w_sel_last;
      r_out_ch    <= w_gidx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_ch    = r_out_ch;

endmodule
